led_seq_ctrl: RTL and testbench
===============================

LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 270_000, consecutive stable samples before a button level is accepted (10 ms at 27 MHz).
REQ-002 Parameter BASE_PERIOD, default 13_500_000, rotation period in clk cycles at speed 0.
REQ-003 Port clk  input  1  system clock; all state on its rising edge.
REQ-004 Port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 Port button_0  input  1  "stop/pause" button, active-low, asynchronous to clk.
REQ-006 Port button_1  input  1  "start/speed" button, active-low, asynchronous to clk.
REQ-007 Port led  output  3  LED pattern driven to the board.
REQ-008 Port tick  output  1  one-cycle pulse in the cycle led rotates.
REQ-009 Port state  output  2  current FSM state: STOP=0, RUN=1, PAUSE=2.
REQ-010 Port speed  output  2  current speed level, 0..3.

Function
REQ-011 Each button SHALL pass through a 2-flop synchronizer, then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
REQ-012 A press event SHALL be a single-cycle pulse on the 1->0 transition of the debounced level; release generates no event; a held button generates exactly one event.
REQ-013 Press-to-event latency SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles for a clean press.
REQ-014 FSM states STOP, RUN, PAUSE; transitions on press events only:
 - STOP: b1 -> RUN (period counter 0); b0 -> stay STOP.
 - RUN: b1 -> RUN, speed <= speed+1 modulo 4 (3 wraps to 0), period counter cleared; b0 -> PAUSE.
 - PAUSE: b1 -> RUN, period counter retained; b0 -> STOP.
REQ-015 Simultaneous b0 and b1 events in one cycle SHALL force STOP from any state.
REQ-016 Entry to STOP SHALL load led=3'b110, speed=0, period counter=0 in the same cycle.
REQ-017 Active period SHALL be BASE_PERIOD >> speed cycles; period counter width SHALL be $clog2(BASE_PERIOD).
REQ-018 In RUN, counter increments each cycle; when counter == period-1: counter <= 0, led <= {led[1:0], led[2]}, tick = 1 that cycle.
REQ-019 tick SHALL be 0 in STOP and PAUSE and in the cycle a press event is processed.
REQ-020 First rotation after STOP->RUN SHALL occur exactly period cycles after the transition cycle.
REQ-021 led SHALL always hold exactly one 0 bit (rotation of 3'b110); no other pattern is reachable.

Reset
REQ-022 rst_n low SHALL asynchronously set state=STOP, led=3'b110, speed=0, tick=0, period counter 0, debounced levels 1 (released), synchronizer flops 1, debounce counters 0.
REQ-023 Reset asserted mid-RUN or mid-debounce SHALL discard all progress; no press event is generated on reset release even if a button is held low (level must first be accepted as 0 from the released state, then produces one event).

Structure
REQ-024 Package led_seq_pkg SHALL hold the state enum (STOP/RUN/PAUSE, 2 bits), LED_INIT=3'b110 and the speed width constant.
REQ-025 Sub-module button_debounce (synchronizer + debouncer + press-event pulse, parameter DEBOUNCE_CYCLES) SHALL be instantiated once per button.

Verification (DEBOUNCE_CYCLES=4, BASE_PERIOD=16)
REQ-026 Reset then b1 pressed 20 cycles -> state RUN; led 110->101 after 16 cycles, ->011 after 32, tick pulses exactly at those cycles.
REQ-027 b1 bounce 1-0-1-0 at 1-cycle spacing then held low -> exactly one press event, one STOP->RUN transition.
REQ-028 In RUN, b1 pressed 4 times -> speed 1,2,3,0; at speed 3 rotation every 2 cycles.
REQ-029 RUN, b0 at counter=10 -> PAUSE, led frozen, tick 0; b1 -> RUN, next rotation 6 cycles later; b0, b0 -> STOP, led=110, speed=0.
REQ-030 b0 and b1 released and pressed in the same cycle from RUN -> STOP in one event cycle.
REQ-031 rst_n pulsed low mid-RUN with b1 held -> outputs at reset values, state stays STOP until b1 released and pressed again.

Source files
------------

// File: rtl/led_seq_pkg.sv
//==========================================================================
// Module : led_seq_pkg
// Brief  : Shared types and constants for the LED sequencer.
// Rev    : 1.0
//==========================================================================
`timescale 1ns/1ps
`default_nettype none

package led_seq_pkg;

   typedef enum logic [1:0] {
      STOP  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   localparam logic [2:0] LED_INIT = 3'b110;
   localparam int         SPEED_W  = 2;

   function automatic logic [2:0] rotate_led(input logic [2:0] value);
      return {value[1:0], value[2]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/led_seq_ctrl_debounce.sv
//==========================================================================
// Module : button_debounce
// Brief  : Active-low button synchronizer, debouncer and press-event pulse.
// Rev    : 1.0
//==========================================================================
`timescale 1ns/1ps
`default_nettype none

module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 270_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic button_n,
   output logic press
);

   localparam int                c_cnt_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(DEBOUNCE_CYCLES - 1);

   logic [1:0]         r_sync;
   logic               r_level;
   logic [c_cnt_w-1:0] r_cnt;
   logic               r_press;

   // r_cnt counts consecutive samples that disagree with the accepted level;
   // any agreeing sample restarts the count, so bounces never accumulate.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync  <= 2'b11;
         r_level <= 1'b1;
         r_cnt   <= '0;
         r_press <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], button_n};
         r_press <= 1'b0;
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
            r_press <= r_level;
         end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
         end
      end
   end

   assign press = r_press;

endmodule

`default_nettype wire

// File: rtl/led_seq_ctrl.sv
//==========================================================================
// Module : led_seq_ctrl
// Brief  : Two-button STOP/RUN/PAUSE controller rotating a 3-bit LED pattern.
// Rev    : 1.0
//==========================================================================
`timescale 1ns/1ps
`default_nettype none

module led_seq_ctrl
   import led_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 270_000,
   parameter int BASE_PERIOD     = 13_500_000
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         button_0,
   input  logic         button_1,
   output logic [2:0]   led,
   output logic         tick,
   output logic [1:0]   state,
   output logic [1:0]   speed
);

   localparam int c_cnt_w = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [2:0]           r_led;
   logic [2:0]           w_led_nxt;
   logic [SPEED_W-1:0]   r_speed;
   logic [SPEED_W-1:0]   w_speed_nxt;
   logic [c_cnt_w-1:0]   r_cnt;
   logic [c_cnt_w-1:0]   w_cnt_nxt;
   logic [c_cnt_w-1:0]   w_period_m1;
   logic                 w_tick;
   logic                 w_ev0;
   logic                 w_ev1;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b0 (
      .clk      (clk),
      .rst_n    (rst_n),
      .button_n (button_0),
      .press    (w_ev0)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b1 (
      .clk      (clk),
      .rst_n    (rst_n),
      .button_n (button_1),
      .press    (w_ev1)
   );

   // The full period may not fit the counter, but period-1 always does.
   assign w_period_m1 = c_cnt_w'((BASE_PERIOD >> r_speed) - 1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= STOP;
         r_led   <= LED_INIT;
         r_speed <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_led   <= w_led_nxt;
         r_speed <= w_speed_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_led_nxt   = r_led;
      w_speed_nxt = r_speed;
      w_cnt_nxt   = r_cnt;
      w_tick      = 1'b0;
      if (w_ev0 && w_ev1) begin
         w_state_nxt = STOP;
         w_led_nxt   = LED_INIT;
         w_speed_nxt = '0;
         w_cnt_nxt   = '0;
      end else begin
         case (r_state)
            STOP: begin
               if (w_ev1) begin
                  w_state_nxt = RUN;
                  w_cnt_nxt   = '0;
               end
            end
            RUN: begin
               if (w_ev1) begin
                  w_speed_nxt = r_speed + SPEED_W'(1);
                  w_cnt_nxt   = '0;
               end else if (w_ev0) begin
                  w_state_nxt = PAUSE;
               end else if (r_cnt == w_period_m1) begin
                  w_cnt_nxt = '0;
                  w_led_nxt = rotate_led(r_led);
                  w_tick    = 1'b1;
               end else begin
                  w_cnt_nxt = r_cnt + c_cnt_w'(1);
               end
            end
            PAUSE: begin
               if (w_ev1) begin
                  w_state_nxt = RUN;
               end else if (w_ev0) begin
                  w_state_nxt = STOP;
                  w_led_nxt   = LED_INIT;
                  w_speed_nxt = '0;
                  w_cnt_nxt   = '0;
               end
            end
            default: begin
               w_state_nxt = STOP;
               w_led_nxt   = LED_INIT;
               w_speed_nxt = '0;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign led   = r_led;
   assign tick  = w_tick;
   assign state = r_state;
   assign speed = r_speed;

endmodule

`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
//==========================================================================
// Module : tb_led_seq_ctrl
// Brief  : Directed self-checking bench for led_seq_ctrl (debounce 4, period 16).
// Rev    : 1.0
//==========================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_led_seq_ctrl;

   localparam int DEB = 4;
   localparam int PER = 16;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       button_0 = 1'b1;
   logic       button_1 = 1'b1;
   logic [2:0] led;
   logic       tick;
   logic [1:0] state;
   logic [1:0] speed;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_seq_ctrl #(.DEBOUNCE_CYCLES(DEB), .BASE_PERIOD(PER)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .button_0 (button_0),
      .button_1 (button_1),
      .led      (led),
      .tick     (tick),
      .state    (state),
      .speed    (speed)
   );

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; button_0 = 1'b1; button_1 = 1'b1;
      step(2);
      rst_n = 1'b1;
      step(2);
   endtask

   // Returns right after the edge on which the press event is processed.
   task automatic press(input int which);
      if (which == 0) button_0 = 1'b0; else button_1 = 1'b0;
      step(DEB + 3);
      button_0 = 1'b1; button_1 = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; button_0 = 1'b1; button_1 = 1'b1;
      step(2);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++; if (led !== 3'b110) begin errors++; $display("FAIL reset_led: got %b want 110", led); end
      checks++; if (speed !== 2'd0) begin errors++; $display("FAIL reset_speed: got %0d want 0", speed); end
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", tick); end
      rst_n = 1'b1;
      step(3);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_idle: got %0d want 0", state); end
   endtask

   task automatic test_start_rotate();
      logic       exp_tick;
      logic [2:0] exp_led;
      do_reset();
      button_1 = 1'b0;
      step(DEB + 2);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL start_latency_early: got %0d want 0", state); end
      step(1);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_run: got %0d want 1", state); end
      for (int k = 1; k <= 32; k++) begin
         exp_tick = (k == 16) || (k == 32);
         exp_led  = (k <= 16) ? 3'b110 : 3'b101;
         checks++; if (tick !== exp_tick) begin errors++; $display("FAIL start_tick k=%0d: got %b want %b", k, tick, exp_tick); end
         checks++; if (led !== exp_led) begin errors++; $display("FAIL start_led k=%0d: got %b want %b", k, led, exp_led); end
         if (k == 14) button_1 = 1'b1;
         step(1);
      end
      checks++; if (led !== 3'b011) begin errors++; $display("FAIL start_led_second: got %b want 011", led); end
      checks++; if (speed !== 2'd0) begin errors++; $display("FAIL start_speed: got %0d want 0", speed); end
   endtask

   task automatic test_bounce();
      int         runs;
      logic [1:0] prev;
      do_reset();
      button_1 = 1'b0; step(1);
      button_1 = 1'b1; step(1);
      button_1 = 1'b0;
      runs = 0;
      prev = state;
      for (int k = 0; k < 40; k++) begin
         step(1);
         if (prev == 2'd0 && state == 2'd1) runs++;
         prev = state;
      end
      checks++; if (runs !== 1) begin errors++; $display("FAIL bounce_transitions: got %0d want 1", runs); end
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL bounce_state: got %0d want 1", state); end
      checks++; if (speed !== 2'd0) begin errors++; $display("FAIL bounce_speed: got %0d want 0", speed); end
      button_1 = 1'b1;
   endtask

   task automatic test_speed();
      logic [1:0] exp_speed;
      do_reset();
      press(1);
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < 8; k++) begin
            if (i == 3) begin
               checks++; if (tick !== ((k % 2) == 1)) begin errors++; $display("FAIL speed3_tick k=%0d: got %b", k, tick); end
               if (k == 0) begin
                  checks++; if (led !== 3'b101) begin errors++; $display("FAIL speed3_led0: got %b want 101", led); end
               end
               if (k == 2) begin
                  checks++; if (led !== 3'b011) begin errors++; $display("FAIL speed3_led2: got %b want 011", led); end
               end
            end
            step(1);
         end
         press(1);
         exp_speed = 2'((i + 1) % 4);
         checks++; if (speed !== exp_speed) begin errors++; $display("FAIL speed_step %0d: got %0d want %0d", i, speed, exp_speed); end
      end
      checks++; if (led !== 3'b011) begin errors++; $display("FAIL speed_final_led: got %b want 011", led); end
   endtask

   task automatic test_pause();
      do_reset();
      press(1);
      step(4);
      press(0);
      checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_state: got %0d want 2", state); end
      for (int k = 0; k < 20; k++) begin
         checks++; if (tick !== 1'b0 || led !== 3'b110) begin errors++; $display("FAIL pause_frozen k=%0d: tick %b led %b want 0 110", k, tick, led); end
         step(1);
      end
      press(1);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL resume_state: got %0d want 1", state); end
      step(4);
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL resume_early_tick: got %b want 0", tick); end
      step(1);
      checks++; if (tick !== 1'b1 || led !== 3'b110) begin errors++; $display("FAIL resume_tick: tick %b led %b want 1 110", tick, led); end
      step(1);
      checks++; if (led !== 3'b101) begin errors++; $display("FAIL resume_rotate: got %b want 101", led); end
      step(8);
      press(0);
      checks++; if (state !== 2'd2 || led !== 3'b101) begin errors++; $display("FAIL pause2: state %0d led %b want 2 101", state, led); end
      step(8);
      press(0);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL stop_state: got %0d want 0", state); end
      checks++; if (led !== 3'b110 || speed !== 2'd0) begin errors++; $display("FAIL stop_load: led %b speed %0d want 110 0", led, speed); end
   endtask

   task automatic test_simul();
      do_reset();
      press(1);
      step(8);
      press(1);
      step(20);
      checks++; if (speed !== 2'd1 || led !== 3'b011) begin errors++; $display("FAIL simul_pre: speed %0d led %b want 1 011", speed, led); end
      button_0 = 1'b0; button_1 = 1'b0;
      step(DEB + 2);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL simul_early: got %0d want 1", state); end
      step(1);
      checks++; if (state !== 2'd0) begin errors++; $display("FAIL simul_state: got %0d want 0", state); end
      checks++; if (speed !== 2'd0 || led !== 3'b110 || tick !== 1'b0) begin errors++; $display("FAIL simul_load: speed %0d led %b tick %b want 0 110 0", speed, led, tick); end
      button_0 = 1'b1; button_1 = 1'b1;
      step(10);
   endtask

   task automatic test_reset_mid();
      int bad;
      do_reset();
      press(1);
      step(20);
      button_1 = 1'b0;
      step(3);
      rst_n = 1'b0;
      #1;
      checks++; if (state !== 2'd0 || led !== 3'b110) begin errors++; $display("FAIL midreset_async: state %0d led %b want 0 110", state, led); end
      checks++; if (speed !== 2'd0 || tick !== 1'b0) begin errors++; $display("FAIL midreset_speed_tick: speed %0d tick %b want 0 0", speed, tick); end
      step(2);
      rst_n = 1'b1;
      step(1);
      button_1 = 1'b1;
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         step(1);
         if (state !== 2'd0) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL midreset_no_event: %0d cycles out of STOP want 0", bad); end
      press(1);
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL midreset_repress: got %0d want 1", state); end
   endtask

   initial begin
      test_reset();
      test_start_rotate();
      test_bounce();
      test_speed();
      test_pause();
      test_simul();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
